// File: rtl/conv_frame_controller.sv
// rtl/conv_frame_controller.sv - frame sequencer around a 3x3 convolution filter
// Loads a preset 3x3 kernel, gates exactly IMG_WIDTH*IMG_HEIGHT pixels into the
// filter, forwards the same number of filtered pixels downstream with m_last on
// the final one, then pulses done for one cycle.
// Optional macro CONV_CTRL_WATCHDOG_EN: DRAIN watchdog that sets timeout_err.
// Ports:
//   clk, rst_n               clock, synchronous active-low reset
//   start, kernel_sel        frame start and preset index (sampled in IDLE)
//   busy, done, timeout_err  host status
//   s_valid/s_ready/s_data   upstream pixel stream
//   f_x_*                    stream into the filter
//   f_y_*                    stream out of the filter
//   m_valid/m_ready/m_data/m_last  downstream stream
//   kernel_flat              coefficients, [r][c] at bits [(r*3+c)*W +: W]
//   in_count, out_count      pixels accepted by the filter / emitted downstream
module conv_frame_controller #(
    parameter int IMG_WIDTH      = 640,
    parameter int IMG_HEIGHT     = 480,
    parameter int W              = 8,
    parameter int TIMEOUT_CYCLES = 4096,
    localparam int N             = IMG_WIDTH * IMG_HEIGHT,
    localparam int CW            = $clog2(N + 1)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [2:0]      kernel_sel,
    output logic            busy,
    output logic            done,
    output logic            timeout_err,
    input  logic            s_valid,
    output logic            s_ready,
    input  logic [W-1:0]    s_data,
    output logic            f_x_valid,
    input  logic            f_x_ready,
    output logic [W-1:0]    f_x_data,
    input  logic            f_y_valid,
    output logic            f_y_ready,
    input  logic [W-1:0]    f_y_data,
    output logic            m_valid,
    input  logic            m_ready,
    output logic [W-1:0]    m_data,
    output logic            m_last,
    output logic [9*W-1:0]  kernel_flat,
    output logic [CW-1:0]   in_count,
    output logic [CW-1:0]   out_count
);

    localparam logic [CW-1:0] N_CNT    = CW'(N);
    localparam logic [CW-1:0] N_M1_CNT = CW'(N - 1);

    // The largest preset coefficient (+12) needs 5 signed bits.
    if (W < 5 || N < 1 || TIMEOUT_CYCLES < 1) begin : g_cfg_check
        $error("conv_frame_controller: invalid W, frame size or TIMEOUT_CYCLES");
    end

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_STREAM,
        ST_DRAIN,
        ST_DONE
    } state_t;

    state_t          state_q, state_d;
    logic [2:0]      sel_q, sel_d;
    logic [3:0]      load_idx_q, load_idx_d;
    logic [9*W-1:0]  kernel_q, kernel_d;
    logic [CW-1:0]   in_q, in_d;
    logic [CW-1:0]   out_q, out_d;
    logic            in_open, out_open;
    logic            x_hs, m_hs;

`ifdef CONV_CTRL_WATCHDOG_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] WD_LAST = TW'(TIMEOUT_CYCLES - 1);
    logic [TW-1:0]   wd_q, wd_d;
    logic            terr_q, terr_d;
`endif

    // Row-major preset ROM; index 4 is the centre tap.
    function automatic logic [W-1:0] preset_coef(input logic [2:0] sel, input logic [3:0] idx);
        int v;
        v = 0;
        case (sel)
            3'd0: v = 1;
            3'd1: v = (idx == 4'd4) ? 5  : (idx[0] ? -1 : 0);
            3'd2: v = (idx == 4'd4) ? 8  : -1;
            3'd3: v = (idx == 4'd4) ? 12 : -1;
            3'd4: v = (idx == 4'd4) ? 2  : (idx[0] ? -1 : 0);
            3'd5: v = (idx == 4'd4) ? 4  : (idx[0] ? -1 : 0);
            3'd6: begin
                case (idx)
                    4'd0, 4'd2: v = -1;
                    4'd1:       v = -2;
                    4'd6, 4'd8: v = 1;
                    4'd7:       v = 2;
                    default:    v = 0;
                endcase
            end
            default: v = (idx == 4'd4) ? 1 : 0;
        endcase
        return v[W-1:0];
    endfunction

    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        load_idx_d = load_idx_q;
        kernel_d   = kernel_q;
        in_d       = in_q;
        out_d      = out_q;
`ifdef CONV_CTRL_WATCHDOG_EN
        wd_d       = '0;
        terr_d     = terr_q;
`endif

        // Input gate closes at N accepted pixels; output gate at N emitted.
        // A closed output gate keeps f_y_ready high so stray filter results drain away.
        in_open   = (state_q == ST_STREAM) && (in_q != N_CNT);
        out_open  = ((state_q == ST_STREAM) || (state_q == ST_DRAIN)) && (out_q != N_CNT);
        f_x_valid = in_open && s_valid;
        s_ready   = in_open && f_x_ready;
        f_x_data  = s_data;
        m_valid   = out_open && f_y_valid;
        f_y_ready = out_open ? m_ready : 1'b1;
        m_data    = f_y_data;
        m_last    = m_valid && (out_q == N_M1_CNT);

        x_hs = f_x_valid && f_x_ready;
        m_hs = m_valid && m_ready;
        if (x_hs) in_d  = in_q + 1'b1;
        if (m_hs) out_d = out_q + 1'b1;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    sel_d      = kernel_sel;
                    load_idx_d = '0;
                    in_d       = '0;
                    out_d      = '0;
`ifdef CONV_CTRL_WATCHDOG_EN
                    terr_d     = 1'b0;
`endif
                    state_d    = ST_LOAD;
                end
            end
            ST_LOAD: begin
                kernel_d[int'(load_idx_q)*W +: W] = preset_coef(sel_q, load_idx_q);
                if (load_idx_q == 4'd8) begin
                    state_d = ST_STREAM;
                end else begin
                    load_idx_d = load_idx_q + 1'b1;
                end
            end
            ST_STREAM: begin
                // Degenerate pipelines may finish the output side in the same cycle.
                if (x_hs && (in_q == N_M1_CNT)) begin
                    state_d = (out_d == N_CNT) ? ST_DONE : ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (out_q == N_CNT) begin
                    state_d = ST_DONE;
                end
`ifdef CONV_CTRL_WATCHDOG_EN
                else if (m_hs) begin
                    wd_d = '0;
                end else if (wd_q == WD_LAST) begin
                    // This edge is the TIMEOUT_CYCLES-th idle cycle.
                    terr_d  = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    wd_d = wd_q + 1'b1;
                end
`endif
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            sel_q      <= '0;
            load_idx_q <= '0;
            kernel_q   <= '0;
            in_q       <= '0;
            out_q      <= '0;
`ifdef CONV_CTRL_WATCHDOG_EN
            wd_q       <= '0;
            terr_q     <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            sel_q      <= sel_d;
            load_idx_q <= load_idx_d;
            kernel_q   <= kernel_d;
            in_q       <= in_d;
            out_q      <= out_d;
`ifdef CONV_CTRL_WATCHDOG_EN
            wd_q       <= wd_d;
            terr_q     <= terr_d;
`endif
        end
    end

    assign busy        = (state_q != ST_IDLE);
    assign done        = (state_q == ST_DONE);
    assign kernel_flat = kernel_q;
    assign in_count    = in_q;
    assign out_count   = out_q;
`ifdef CONV_CTRL_WATCHDOG_EN
    assign timeout_err = terr_q;
`else
    assign timeout_err = 1'b0;
`endif

endmodule
